// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, instruction
// width, PC step and default reset vector.
package cpu_pkg;
  localparam int          INSN_W       = 32;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,   // queue full, no request
    ST_REQ,    // request on the bus, response is kept
    ST_SQUASH  // request on the bus, response is dropped
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, insn} entries with flush. The head
// is kept in its own register so the decoder sees a flopped value.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int AW     = $clog2(QDEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [AW:0]  count,
  output fetch_entry_t head
);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  fetch_entry_t   mem [QDEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           push_ok, pop_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL) || pop_ok);

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      // New data becomes head when the queue is (or is about to be) empty.
      if (push_ok && ((count == '0) || (pop_ok && count == ONE)))
        head <= push_data;
      else if (pop_ok && count > ONE)
        head <= mem[rd_ptr + AW'(1)];
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding memory request FSM feeding a
// small fetch queue, with redirect flush and squash of in-flight responses.
// Optional IFETCH_PERF_CNT_EN adds a fetch_count output of kept fetches.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INSN_W-1:0] ins,
  output logic [31:0]       ins_pc
`ifdef IFETCH_PERF_CNT_EN
  ,output logic [31:0]      fetch_count
`endif
);
  localparam int          AW    = $clog2(QDEPTH);
  localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pend_pc, rpc;
  logic [AW:0]  count, cnt_after;
  logic         push, pop;
  fetch_entry_t head;

  assign rpc       = align_pc(redirect_pc);
  assign imem_req  = (state != ST_IDLE);
  assign imem_addr = pc;
  assign ins_valid = (count != '0);
  assign ins       = head.insn;
  assign ins_pc    = head.pc;
  // A redirect kills both the returning data and the decoder's pop.
  assign push      = (state == ST_REQ) && imem_ready && !redirect_valid;
  assign pop       = ins_valid && ins_ready && !redirect_valid;
  assign cnt_after = count + (AW+1)'(1) - (AW+1)'(pop);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (redirect_valid || count < QFULL) state_nxt = ST_REQ;
      ST_REQ:
        if (redirect_valid)  state_nxt = imem_ready ? ST_REQ : ST_SQUASH;
        else if (imem_ready) state_nxt = (cnt_after < QFULL) ? ST_REQ : ST_IDLE;
      ST_SQUASH:
        if (imem_ready) state_nxt = ST_REQ;
      default: state_nxt = ST_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_REQ;
    else        state <= state_nxt;
  end

  // Fetch address and the target parked while a squashed response drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE:
          if (redirect_valid) pc <= rpc;
        ST_REQ:
          if (redirect_valid) begin
            if (imem_ready) pc <= rpc;
            else            pend_pc <= rpc;
          end else if (imem_ready) begin
            pc <= pc + PC_INC;
          end
        ST_SQUASH:
          if (imem_ready)          pc <= redirect_valid ? rpc : pend_pc;
          else if (redirect_valid) pend_pc <= rpc;
        default: ;
      endcase
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ('{pc: pc, insn: imem_rdata}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

`ifdef IFETCH_PERF_CNT_EN
  // Count of responses actually written into the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fetch_count <= '0;
    else if (push) fetch_count <= fetch_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic, checked every cycle against a transaction-level queue model.
module tb_instruction_fetch;
  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  instruction_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,.fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: the queue contents, whether a request is on the bus,
  // its address, and whether its data is to be dropped (then where to go).
  typedef struct { logic [31:0] pc; logic [31:0] insn; } ment_t;
  ment_t       mq[$];
  bit          m_req, m_drop;
  logic [31:0] m_addr, m_tgt, m_cnt;

  task automatic m_reset();
    mq.delete();
    m_req  = 1'b1;
    m_drop = 1'b0;
    m_addr = RPC;
    m_tgt  = RPC;
    m_cnt  = 0;
  endtask

  task automatic m_step(input bit rdy, input bit ir, input bit rv,
                        input logic [31:0] rpc, input logic [31:0] rdata);
    int          sz;
    logic [31:0] t;
    ment_t       e;
    sz = mq.size();
    if (rv) begin
      mq.delete();
      t = rpc & ~32'h3;
      if (m_req && !rdy) begin
        m_drop = 1'b1;
        m_tgt  = t;
      end else begin
        m_req  = 1'b1;
        m_drop = 1'b0;
        m_addr = t;
      end
    end else begin
      if (sz > 0 && ir) void'(mq.pop_front());
      if (m_req && rdy) begin
        if (m_drop) begin
          m_drop = 1'b0;
          m_addr = m_tgt;
        end else begin
          e.pc = m_addr;
          e.insn = rdata;
          mq.push_back(e);
          m_cnt  = m_cnt + 1;
          m_addr = m_addr + 32'd4;
          if (mq.size() >= QD) m_req = 1'b0;
        end
      end else if (!m_req && sz < QD) begin
        m_req = 1'b1;
      end
    end
  endtask

  // One clock: compare outputs to the model, drive inputs, advance the model.
  task automatic cyc(input bit rdy, input bit ir, input bit rv, input logic [31:0] rpc);
    logic [31:0] d;
    d = $urandom();
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("imem_addr", imem_addr, m_addr);
    chk("ins_valid", 32'(ins_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("ins", ins, mq[0].insn);
      chk("ins_pc", ins_pc, mq[0].pc);
    end
`ifdef IFETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_cnt);
`endif
    imem_ready     = rdy;
    ins_ready      = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = d;
    @(posedge clk);
    m_step(rdy, ir, rv, rpc, d);
  endtask

  task automatic hard_reset();
    #3;
    rst_n          = 1'b0;
    imem_ready     = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rdata     = '0;
    #1;
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_imem_addr", imem_addr, RPC);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_fetch_count", fetch_count, 32'd0);
`endif
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RPC);
  endtask

  initial begin
    rst_n = 1'b1;
    hard_reset();

    // Streaming: one instruction per cycle, 1-cycle accept-to-valid latency.
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 0);
      #1;
      chk("seq_valid", 32'(ins_valid), 32'd1);
      chk("seq_pc", ins_pc, 32'(4 * k));
    end

    // Back-pressure: queue fills after two accepts, one pop reopens fetch.
    cyc(1, 0, 1, 32'h0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    #1 chk("full_req", 32'(imem_req), 32'd0);
    chk("full_head", ins_pc, 32'h0);
    cyc(1, 1, 0, 0);
    #1 chk("pop_still_idle", 32'(imem_req), 32'd0);
    cyc(1, 0, 0, 0);
    #1 chk("reopen_req", 32'(imem_req), 32'd1);
    chk("reopen_addr", imem_addr, 32'h8);
    cyc(1, 0, 0, 0);
    #1 chk("refull_req", 32'(imem_req), 32'd0);

    // Redirect while a request is stalled: old address held, data dropped.
    cyc(1, 1, 1, 32'h10);
    cyc(0, 1, 0, 0);
    #1 chk("stall_addr0", imem_addr, 32'h10);
    cyc(0, 1, 1, 32'h100);
    #1 chk("stall_addr1", imem_addr, 32'h10);
    chk("stall_req1", 32'(imem_req), 32'd1);
    cyc(0, 1, 0, 0);
    #1 chk("stall_addr2", imem_addr, 32'h10);
    cyc(1, 1, 0, 0);
    #1 chk("squash_addr", imem_addr, 32'h100);
    chk("squash_empty", 32'(ins_valid), 32'd0);
    cyc(1, 0, 0, 0);
    #1 chk("redir_first_valid", 32'(ins_valid), 32'd1);
    chk("redir_first_pc", ins_pc, 32'h100);

    // Second redirect during squash replaces the pending target.
    cyc(0, 0, 1, 32'h40);
    cyc(0, 0, 1, 32'h302);
    cyc(1, 0, 0, 0);
    #1 chk("resquash_addr", imem_addr, 32'h300);
    chk("resquash_empty", 32'(ins_valid), 32'd0);

    // Redirect coincident with accept and pop: flushed, aligned target.
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 32'h203);
    #1 chk("coinc_empty", 32'(ins_valid), 32'd0);
    chk("coinc_req", 32'(imem_req), 32'd1);
    chk("coinc_addr", imem_addr, 32'h200);

    // PC wraps at the top of the address space.
    cyc(1, 1, 1, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0);
    #1 chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", ins_pc, 32'hFFFF_FFFC);

    // Random traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) hard_reset();
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0, $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, fetch-queue entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_ready  input  1  memory accepts request; imem_rdata valid in the same cycle.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-010 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0.
REQ-011 SHALL have port ins_valid  output  1  queue head is valid for the decoder.
REQ-012 SHALL have port ins_ready  input  1  decoder consumes the head this cycle.
REQ-013 SHALL have port ins  output  32  instruction word to the decoder.
REQ-014 SHALL have port ins_pc  output  32  address of ins.

Function
REQ-015 SHALL implement FSM states IDLE (queue full, imem_req=0), REQ (imem_req=1), SQUASH (imem_req=1, response discarded).
REQ-016 SHALL enter REQ from IDLE when registered count < QDEPTH; imem_req SHALL depend on registered state only, with no combinational path from ins_ready.
REQ-017 SHALL hold imem_req and imem_addr stable from assertion until the cycle imem_ready=1, with at most one request outstanding.
REQ-018 In REQ with imem_ready=1, SHALL push {pc, imem_rdata} at the clock edge, advance pc by 4 (mod 2^32 wrap), and remain in REQ if count after push < QDEPTH, else go to IDLE.
REQ-019 SHALL give 1-cycle latency from accept (imem_ready=1) to ins_valid=1 when the queue was empty, and sustain 1 instruction/cycle when imem_ready is held high and ins_ready is held high.
REQ-020 SHALL pop the head when ins_valid & ins_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-021 ins_valid SHALL equal (count != 0); ins/ins_pc SHALL be registered queue-head values.
REQ-022 On redirect_valid, SHALL flush the queue (count=0, ins_valid=0 next cycle) and set pc=redirect_pc; redirect SHALL override any same-cycle push or pop.
REQ-023 On redirect while imem_req=1 and imem_ready=0, SHALL enter SQUASH, keep imem_addr at the old address until imem_ready, discard that data, and then enter REQ with the redirect pc.
REQ-024 On redirect in the same cycle as imem_ready=1, SHALL discard the returning data and enter REQ at redirect_pc.
REQ-025 On a second redirect in SQUASH, SHALL overwrite the pending pc and stay in SQUASH.

Reset
REQ-026 While rst_n=0, SHALL set state=REQ, pc=RESET_PC, count=0, queue pointers=0, ins_valid=0, ins=0, and ins_pc=0.
REQ-027 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n rises.
REQ-028 Reset assertion mid-request SHALL abandon the request immediately; the memory side SHALL tolerate this.

Configuration
REQ-029 With macro IFETCH_PERF_CNT_EN defined, SHALL add output fetch_count[31:0]: increments on each push, wraps at 2^32, cleared by reset, excludes discarded responses.
REQ-030 Without IFETCH_PERF_CNT_EN, SHALL omit the port and its counter, with all other behaviour identical.

Structure
REQ-031 SHALL place the FSM state enum, instruction width (32), PC increment (4), and RESET_PC default in shared package cpu_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_queue (synchronous FIFO with flush, push, pop, count, and head outputs).

Verification
REQ-033 Reset then imem_ready=1 and ins_ready=1 constant -> ins_pc sequence 0,4,8,12 on consecutive cycles from cycle 2 after reset.
REQ-034 ins_ready=0, imem_ready=1, QDEPTH=2 -> exactly 2 accepts (addr 0,4), then imem_req=0; ins_ready=1 for one cycle -> one new request at addr 8.
REQ-035 imem_ready=0 for 3 cycles at addr 0x10, redirect to 0x100 in cycle 1 -> imem_addr stays 0x10 until ready, data dropped, next request addr 0x100, first ins_pc=0x100.
REQ-036 Redirect to 0x203 coincident with imem_ready=1 and a pop -> queue empty next cycle, next imem_addr=0x200.
REQ-037 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-038 IFETCH_PERF_CNT_EN defined, 5 accepts with 1 squashed -> fetch_count=4.
